// File: rtl/fifo_rd_stream.sv
// ============================================================================
// Module  : fifo_rd_stream
// Brief   : Read-side drain engine for the dual-clock FIFO. Pops the FIFO
//           under a credit rule and re-presents words as a valid/ready stream
//           through a small circular output buffer.
// Options : RD_STREAM_CNT_EN adds the word_cnt delivered-word counter port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_stream #(
    parameter int DSIZE      = 8,
    parameter int OBUF_DEPTH = 2,
    parameter int CNTW       = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rd_en,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    input  logic             out_ready
`ifdef RD_STREAM_CNT_EN
    ,
    output logic [CNTW-1:0]  word_cnt
`endif
);

    localparam int C_PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int C_CNT_W = $clog2(OBUF_DEPTH + 1) + 1;

    generate
        if (OBUF_DEPTH < 2 || OBUF_DEPTH > 8 || CNTW < 1) begin : g_bad_param
            $error("fifo_rd_stream: OBUF_DEPTH must be 2..8 and CNTW >= 1");
        end
    endgenerate

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_pend;
    logic [C_PTR_W-1:0] r_head;
    logic [C_PTR_W-1:0] r_tail;
    logic               r_valid;
    logic [DSIZE-1:0]   r_out_data;
    logic [DSIZE-1:0]   r_mem [OBUF_DEPTH];

    logic               w_deq;
    logic [C_CNT_W-1:0] w_level;
    logic [C_CNT_W-1:0] w_cnt_after_deq;
    logic               w_rinc;
    logic [C_PTR_W-1:0] w_head_nxt;
    logic [C_PTR_W-1:0] w_tail_nxt;
    logic [DSIZE-1:0]   w_out_data_nxt;

    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + C_PTR_W'(1);
    endfunction

    assign w_deq           = r_valid & out_ready;
    assign w_cnt_after_deq = r_cnt - C_CNT_W'(w_deq);
    // Occupancy after this edge, counting the word already in flight on rdata.
    assign w_level         = w_cnt_after_deq + C_CNT_W'(r_pend);
    assign w_rinc          = rd_en & ~rempty & (w_level < C_CNT_W'(OBUF_DEPTH));
    assign w_head_nxt      = w_deq  ? ptr_inc(r_head) : r_head;
    assign w_tail_nxt      = r_pend ? ptr_inc(r_tail) : r_tail;

    // When the buffer would be empty after the dequeue, the new head is the
    // word being captured this edge, so bypass it straight from rdata.
    always_comb begin
        w_out_data_nxt = r_out_data;
        if (w_cnt_after_deq == '0) begin
            if (r_pend) begin
                w_out_data_nxt = rdata;
            end
        end else begin
            w_out_data_nxt = r_mem[w_head_nxt];
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_valid    <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_cnt      <= w_level;
            r_pend     <= w_rinc;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_valid    <= (w_level != '0);
            r_out_data <= w_out_data_nxt;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst_n && r_pend) begin
            r_mem[r_tail] <= rdata;
        end
    end

`ifdef RD_STREAM_CNT_EN
    logic [CNTW-1:0] r_word_cnt;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_word_cnt <= '0;
        end else if (w_deq) begin
            r_word_cnt <= r_word_cnt + CNTW'(1);
        end
    end

    assign word_cnt = r_word_cnt;
`endif

    assign rinc      = w_rinc;
    assign out_valid = r_valid;
    assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// Module  : tb_fifo_rd_stream
// Brief   : Self-checking bench for fifo_rd_stream: per-cycle vector table,
//           directed corner sequences and randomized traffic against a queue
//           model of the FIFO and of the expected output stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int D  = 2;
    localparam int CW = 4;

    logic          rclk      = 1'b0;
    logic          rrst_n    = 1'b0;
    logic          rd_en     = 1'b0;
    logic          rempty    = 1'b1;
    logic [DW-1:0] rdata     = '0;
    logic          out_ready = 1'b0;
    logic          rinc;
    logic          out_valid;
    logic [DW-1:0] out_data;
`ifdef RD_STREAM_CNT_EN
    logic [CW-1:0] word_cnt;
    int            wcnt_model = 0;
`endif

    fifo_rd_stream #(.DSIZE(DW), .OBUF_DEPTH(D), .CNTW(CW)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rd_en     (rd_en),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef RD_STREAM_CNT_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    int            n_checks  = 0;
    int            n_errors  = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sb_q[$];
    int            delivered = 0;
    int            pops      = 0;

    typedef struct {
        bit            rd_en;
        bit            out_ready;
        bit            exp_rinc;
        bit            exp_valid;
        bit            chk_data;
        logic [DW-1:0] exp_data;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        rempty = 1'b0;
    endtask

    // One read-clock cycle: sample pre-edge, then advance FIFO and stream models.
    task automatic tick();
        bit            pop, dq, stall, rst_now;
        logic [DW-1:0] od, exp;
        #1;
        pop     = (rinc === 1'b1);
        dq      = (out_valid === 1'b1) && out_ready;
        od      = out_data;
        rst_now = !rrst_n;
        stall   = (out_valid === 1'b1) && !out_ready && rrst_n;
        if (rrst_n) chk("rinc_while_empty", 32'(pop && rempty), 0);
        @(posedge rclk);
        #1;
        if (rst_now) begin
            fifo_q.delete();
            sb_q.delete();
`ifdef RD_STREAM_CNT_EN
            wcnt_model = 0;
`endif
        end else begin
            if (pop && fifo_q.size() > 0) begin
                rdata = fifo_q.pop_front();
                sb_q.push_back(rdata);
                pops++;
            end
            if (dq) begin
                if (sb_q.size() == 0) chk("spurious_word", 32'(od), 32'hFFFF);
                else begin
                    exp = sb_q.pop_front();
                    chk("order", 32'(od), 32'(exp));
                end
                delivered++;
`ifdef RD_STREAM_CNT_EN
                wcnt_model++;
`endif
            end
            chk("occupancy_le_depth", 32'(sb_q.size() <= D), 1);
            if (stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(od));
            end
        end
        rempty = (fifo_q.size() == 0);
`ifdef RD_STREAM_CNT_EN
        chk("word_cnt", 32'(word_cnt), 32'(wcnt_model % 16));
`endif
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        tick();
        tick();
        rrst_n    = 1'b1;
        delivered = 0;
        pops      = 0;
    endtask

    task automatic drain(input int budget, input int target, input string nm);
        for (int i = 0; i < budget && delivered < target; i++) tick();
        chk(nm, 32'(delivered), 32'(target));
    endtask

    vec_t tbl[6];

    initial begin
        // rd_en, out_ready, exp_rinc, exp_valid, chk_data, exp_data
        tbl[0] = '{1, 1, 1, 0, 0, 8'h00};
        tbl[1] = '{1, 1, 1, 0, 0, 8'h00};
        tbl[2] = '{1, 1, 1, 1, 1, 8'h11};
        tbl[3] = '{1, 1, 0, 1, 1, 8'h22};
        tbl[4] = '{1, 1, 0, 1, 1, 8'h33};
        tbl[5] = '{1, 1, 0, 0, 0, 8'h00};

        // Reset state
        do_reset();
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_rinc", 32'(rinc), 0);
        chk("rst_data", 32'(out_data), 0);

        // Basic latency/throughput table
        load(8'h11); load(8'h22); load(8'h33);
        for (int i = 0; i < 6; i++) begin
            rd_en     = tbl[i].rd_en;
            out_ready = tbl[i].out_ready;
            #1;
            chk($sformatf("basic_rinc[%0d]", i), 32'(rinc), 32'(tbl[i].exp_rinc));
            chk($sformatf("basic_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].chk_data)
                chk($sformatf("basic_data[%0d]", i), 32'(out_data), 32'(tbl[i].exp_data));
            tick();
        end
        chk("basic_delivered", 32'(delivered), 3);
        chk("basic_rempty", 32'(rempty), 1);

        // Back-pressure
        do_reset();
        rd_en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) load(8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("bp_pops", 32'(pops), D);
        chk("bp_rinc_off", 32'(rinc), 0);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_head", 32'(out_data), 32'hA0);
        out_ready = 1'b1;
        drain(40, 6, "bp_delivered");
        chk("bp_model_empty", 32'(sb_q.size() + fifo_q.size()), 0);

        // Alternating ready with 64 random words
        do_reset();
        rd_en = 1'b1;
        for (int i = 0; i < 64; i++) load(8'($urandom));
        for (int i = 0; i < 400 && delivered < 64; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        chk("alt_delivered", 32'(delivered), 64);

        // rd_en gating with a word in flight
        do_reset();
        out_ready = 1'b1; rd_en = 1'b1;
        load(8'hC1); load(8'hC2); load(8'hC3);
        #1;
        chk("gate_first_pop", 32'(rinc), 1);
        tick();
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("gate_no_rinc", 32'(rinc), 0);
            tick();
        end
        chk("gate_inflight_delivered", 32'(delivered), 1);
        rd_en = 1'b1;
        #1;
        chk("gate_resume", 32'(rinc), 1);
        drain(20, 3, "gate_all_delivered");

        // Reset mid-stream with buffered and in-flight words
        do_reset();
        rd_en = 1'b1; out_ready = 1'b1;
        load(8'h51); load(8'h52);
        drain(20, 2, "mid_pre_delivered");
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(8'h60 + 8'(i));
        tick(); tick();
        rrst_n = 1'b0;
        tick();
        rrst_n = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_rinc", 32'(rinc), 0);
        chk("mid_rst_data", 32'(out_data), 0);
`ifdef RD_STREAM_CNT_EN
        chk("mid_rst_word_cnt", 32'(word_cnt), 0);
`endif

        // Randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) load(8'($urandom));
            rd_en     = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rd_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100 && (fifo_q.size() + sb_q.size()) > 0; i++) tick();
        chk("rand_drained", 32'(fifo_q.size() + sb_q.size()), 0);
        chk("rand_pops_eq_delivered", 32'(pops), 32'(delivered));

`ifdef RD_STREAM_CNT_EN
        // Counter wrap at CNTW=4
        do_reset();
        rd_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 17; i++) load(8'(i));
        drain(60, 17, "cnt_delivered");
        #1;
        chk("cnt_wrapped", 32'(word_cnt), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
